// File: rtl/rr_decoder_arbiter_pkg.sv
// Shared constants, state encoding and round-robin pick helper for rr_decoder_arbiter.
package rr_decoder_arbiter_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Rotate the request vector right by ptr so the pointed-to requester lands
  // in bit 0, pick the lowest set bit, then undo the rotation by adding ptr
  // back (3-bit add wraps modulo 8).
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   enc;
    dbl = {req, req};
    rot = N_REQ'(dbl >> ptr);
    enc = '0;
    for (int unsigned i = N_REQ; i > 0; i--) begin
      if (rot[i-1]) enc = IDX_W'(i - 1);
    end
    return enc + ptr;
  endfunction

endpackage

// File: rtl/rr_decoder_arbiter_dec3to8.sv
// Pure combinational 3-to-8 decoder with enable; output is all-zero when disabled.
module dec3to8
  import rr_decoder_arbiter_pkg::*;
(
  input  logic             en_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [N_REQ-1:0] dec_o
);

  // One-hot decode of idx_i, gated by en_i.
  always_comb begin
    dec_o = '0;
    if (en_i) dec_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter for eight requesters sharing one decoded select resource.
// Grant is held until DONE or request withdrawal. Optional hold timeout is
// compiled in with macro ARB_TIMEOUT_EN (forced release after HOLD_MAX cycles).
module rr_decoder_arbiter
  import rr_decoder_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N_REQ-1:0] REQ,
  input  logic             DONE,
  output logic [IDX_W-1:0] GNT_IDX,
  output logic             GNT_VLD,
  output logic [N_REQ-1:0] GNT,
  output logic             TIMEOUT
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_range
    $error("rr_decoder_arbiter: HOLD_MAX must be in 1..255");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q,   ptr_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic             vld_q,   vld_d;
  logic             rel_norm;
  logic             rel_force;

  // Normal release: owner finished or dropped its request.
  assign rel_norm = DONE || !REQ[idx_q];

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q,  to_d;

  assign rel_force = (state_q == ST_GRANT) && (cnt_q == HOLD_LAST);

  // Hold counter clears on grant entry and counts every GRANT cycle;
  // TIMEOUT flags a release caused only by the counter.
  always_comb begin
    cnt_d = cnt_q;
    to_d  = 1'b0;
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
      to_d  = rel_force && !rel_norm;
    end
  end

  // Hold counter and timeout pulse registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign TIMEOUT = to_q;
`else
  assign rel_force = 1'b0;
  assign TIMEOUT   = 1'b0;
`endif

  // Next-state logic: arbitrate in IDLE, watch release conditions in GRANT.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    case (state_q)
      ST_IDLE: begin
        if (|REQ) begin
          idx_d   = rr_pick(REQ, ptr_q);
          vld_d   = 1'b1;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (rel_norm || rel_force) begin
          vld_d   = 1'b0;
          ptr_d   = idx_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        vld_d   = 1'b0;
      end
    endcase
  end

  // State, pointer and grant registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
    end
  end

  assign GNT_IDX = idx_q;
  assign GNT_VLD = vld_q;

  dec3to8 u_dec (
    .en_i  (vld_q),
    .idx_i (idx_q),
    .dec_o (GNT)
  );

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Self-checking bench for rr_decoder_arbiter: directed scenarios plus a
// randomized run against a behavioural reference model.
module tb_rr_decoder_arbiter;

  localparam int HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [7:0] REQ;
  logic       DONE;
  logic [2:0] GNT_IDX;
  logic       GNT_VLD;
  logic [7:0] GNT;
  logic       TIMEOUT;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit m_vld;
  int m_idx;
  int m_ptr;
  int m_held;
  bit m_to;

  rr_decoder_arbiter #(.HOLD_MAX(HOLD)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .REQ     (REQ),
    .DONE    (DONE),
    .GNT_IDX (GNT_IDX),
    .GNT_VLD (GNT_VLD),
    .GNT     (GNT),
    .TIMEOUT (TIMEOUT)
  );

  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_vld = 0; m_idx = 0; m_ptr = 0; m_held = 0; m_to = 0;
  endtask

  task automatic model_step();
    bit rn, rf;
    if (m_vld) begin
      rn = DONE || !REQ[m_idx];
      rf = TO_EN && !rn && (m_held == HOLD);
      m_to = rf;
      if (rn || rf) begin
        m_vld = 0;
        m_ptr = (m_idx + 1) % 8;
      end else begin
        m_held++;
      end
    end else begin
      m_to = 0;
      if (REQ != 8'h00) begin
        for (int k = 7; k >= 0; k--)
          if (REQ[(m_ptr + k) % 8]) m_idx = (m_ptr + k) % 8;
        m_vld  = 1;
        m_held = 1;
      end
    end
  endtask

  task automatic tick();
    if (RST_N) model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST_N = 0; REQ = 8'hFF; DONE = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    total++; if (GNT !== 8'h00)  begin bad++; $display("FAIL reset_gnt got=%h want=00", GNT); end
    total++; if (GNT_VLD !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b want=0", GNT_VLD); end
    total++; if (GNT_IDX !== 3'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", GNT_IDX); end
    total++; if (TIMEOUT !== 1'b0) begin bad++; $display("FAIL reset_to got=%b want=0", TIMEOUT); end
    @(negedge CLK);
    RST_N = 1;
    tick();
    total++; if (GNT !== 8'h01 || GNT_IDX !== 3'd0 || GNT_VLD !== 1'b1) begin
      bad++; $display("FAIL reset_first_grant got gnt=%h idx=%0d vld=%b want gnt=01 idx=0 vld=1", GNT, GNT_IDX, GNT_VLD);
    end
  endtask

  task automatic test_fairness();
    logic [7:0] exp_gnt;
    REQ = 8'hFF;
    for (int g = 0; g <= 8; g++) begin
      exp_gnt = 8'h01 << (g % 8);
      total++; if (GNT_VLD !== 1'b1 || GNT_IDX !== 3'(g % 8) || GNT !== exp_gnt) begin
        bad++; $display("FAIL fair_seq[%0d] got idx=%0d vld=%b gnt=%h want idx=%0d gnt=%h", g, GNT_IDX, GNT_VLD, GNT, g % 8, exp_gnt);
      end
      DONE = 0; tick();
      DONE = 1; tick();
      total++; if (GNT_VLD !== 1'b0 || GNT !== 8'h00) begin
        bad++; $display("FAIL fair_idle[%0d] got vld=%b gnt=%h want vld=0 gnt=00", g, GNT_VLD, GNT);
      end
      DONE = 0; tick();
    end
    DONE = 1; tick();
    DONE = 0; REQ = 8'h00; tick();
  endtask

  task automatic test_skipping();
    REQ = 8'h10; tick();
    total++; if (GNT_IDX !== 3'd4 || GNT_VLD !== 1'b1) begin bad++; $display("FAIL skip_setup got idx=%0d want 4", GNT_IDX); end
    DONE = 1; tick();
    DONE = 0; REQ = 8'b0000_0110; tick();
    total++; if (GNT_IDX !== 3'd1 || GNT_VLD !== 1'b1) begin bad++; $display("FAIL skip_first got idx=%0d vld=%b want 1", GNT_IDX, GNT_VLD); end
    DONE = 1; tick();
    DONE = 0; tick();
    total++; if (GNT_IDX !== 3'd2 || GNT_VLD !== 1'b1) begin bad++; $display("FAIL skip_second got idx=%0d vld=%b want 2", GNT_IDX, GNT_VLD); end
    DONE = 1; tick();
    DONE = 0; REQ = 8'hFF; tick();
    total++; if (GNT_IDX !== 3'd3 || GNT_VLD !== 1'b1) begin bad++; $display("FAIL skip_ptr got idx=%0d want 3", GNT_IDX); end
  endtask

  task automatic test_withdrawal();
    REQ = 8'hF7; DONE = 0; tick();
    total++; if (GNT_VLD !== 1'b0 || TIMEOUT !== 1'b0) begin
      bad++; $display("FAIL withdraw got vld=%b to=%b want vld=0 to=0", GNT_VLD, TIMEOUT);
    end
    REQ = 8'h00; tick();
  endtask

  task automatic test_timeout();
    int cycles;
    if (TO_EN) begin
      REQ = 8'h10; DONE = 0; tick();
      cycles = (GNT_VLD === 1'b1) ? 1 : 0;
      for (int k = 0; k < 20 && GNT_VLD === 1'b1; k++) begin
        tick();
        if (GNT_VLD === 1'b1) cycles++;
      end
      total++; if (cycles != HOLD) begin bad++; $display("FAIL to_hold got=%0d want=%0d", cycles, HOLD); end
      total++; if (GNT_VLD !== 1'b0 || TIMEOUT !== 1'b1) begin bad++; $display("FAIL to_pulse got vld=%b to=%b want vld=0 to=1", GNT_VLD, TIMEOUT); end
      tick();
      total++; if (GNT_VLD !== 1'b1 || GNT_IDX !== 3'd4 || TIMEOUT !== 1'b0) begin
        bad++; $display("FAIL to_regrant got vld=%b idx=%0d to=%b want vld=1 idx=4 to=0", GNT_VLD, GNT_IDX, TIMEOUT);
      end
      tick(); tick();
      DONE = 1; tick();
      total++; if (GNT_VLD !== 1'b0 || TIMEOUT !== 1'b0) begin bad++; $display("FAIL to_done_wins got vld=%b to=%b want vld=0 to=0", GNT_VLD, TIMEOUT); end
      DONE = 0; REQ = 8'h00; tick();
    end
  endtask

  task automatic test_reset_mid_grant();
    REQ = 8'h40; DONE = 0; tick();
    total++; if (GNT_IDX !== 3'd6 || GNT_VLD !== 1'b1) begin bad++; $display("FAIL rst_mid_setup got idx=%0d want 6", GNT_IDX); end
    #2;
    RST_N = 0;
    model_reset();
    #1;
    total++; if (GNT !== 8'h00 || GNT_VLD !== 1'b0 || GNT_IDX !== 3'd0) begin
      bad++; $display("FAIL rst_mid_clear got gnt=%h vld=%b idx=%0d want 00/0/0", GNT, GNT_VLD, GNT_IDX);
    end
    @(negedge CLK);
    RST_N = 1; REQ = 8'h41;
    tick();
    total++; if (GNT_IDX !== 3'd0 || GNT_VLD !== 1'b1) begin bad++; $display("FAIL rst_mid_ptr got idx=%0d vld=%b want 0", GNT_IDX, GNT_VLD); end
    DONE = 1; tick();
    DONE = 0;
  endtask

  task automatic test_random();
    logic [7:0] exp_gnt;
    for (int n = 0; n < 400; n++) begin
      REQ  = 8'($urandom) & 8'($urandom);
      DONE = ($urandom_range(0, 3) == 0);
      tick();
      exp_gnt = m_vld ? (8'h01 << m_idx) : 8'h00;
      total++;
      if (GNT_VLD !== m_vld || (m_vld && GNT_IDX !== 3'(m_idx)) || GNT !== exp_gnt || TIMEOUT !== m_to) begin
        bad++;
        $display("FAIL rand[%0d] got vld=%b idx=%0d gnt=%h to=%b want vld=%b idx=%0d gnt=%h to=%b",
                 n, GNT_VLD, GNT_IDX, GNT, TIMEOUT, m_vld, m_idx, exp_gnt, m_to);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_skipping();
    test_withdrawal();
    test_timeout();
    test_reset_mid_grant();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_decoder_arbiter.md
# rr_decoder_arbiter

Round-robin arbiter that shares one 3-to-8 decoded select resource among eight requesters. It selects one requester at a time, holds the grant until the owner signals completion, and drives both the 3-bit grant index and its one-hot decoded form. A fixed rotating priority pointer guarantees fairness. An optional hold timeout forcibly reclaims a stuck grant.

## Interface
- HOLD_MAX, 15: maximum grant hold in cycles before forced release. Legal range 1..255. Used only with ARB_TIMEOUT_EN.
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- REQ  in  8  request vector. REQ[i] high means requester i wants the resource.
- DONE  in  1  current owner finished. Sampled only in GRANT.
- GNT_IDX  out  3  index of the current owner. Registered.
- GNT_VLD  out  1  grant active. Registered.
- GNT  out  8  one-hot grant, equal to decode(GNT_IDX) when GNT_VLD=1, otherwise 8'h00.
- TIMEOUT  out  1  one-cycle pulse on forced release.

## Operation
- State register: IDLE, GRANT. Reset state is IDLE.
- Priority pointer PTR (3 bits, reset 0) names the highest-priority requester.
- In IDLE, with REQ≠0:
  - winner = first i with REQ[i]=1, scanning PTR, PTR+1, … mod 8.
  - Next edge: GNT_IDX←winner, GNT_VLD←1, state←GRANT.
- In IDLE, with REQ=0: no change. DONE is ignored.
- GRANT ends on any of these release conditions, evaluated in order:
  - DONE=1: normal release.
  - REQ[GNT_IDX]=0: requester withdrew; normal release.
  - hold counter == HOLD_MAX−1: forced release (ARB_TIMEOUT_EN only).
- On release, at the next edge:
  - GNT_VLD←0, state←IDLE.
  - PTR←GNT_IDX+1 mod 8 (7 wraps to 0).
  - GNT_IDX keeps its last value.
- DONE and timeout in the same cycle: counts as a normal release, TIMEOUT stays 0.
- REQ changes from non-owners during GRANT have no effect.
- Reset asserted mid-grant:
  - Outputs clear immediately and asynchronously.
  - PTR returns to 0.

## Timing
- Reset values: GNT_IDX=0, GNT_VLD=0, GNT=0, TIMEOUT=0, PTR=0, hold counter=0.
- Grant latency: REQ high before edge k gives GNT_VLD=1 after edge k.
- Release latency: DONE high before edge k gives GNT_VLD=0 after edge k.
- Mandatory one IDLE cycle between consecutive grants.
  - Minimum grant period is 2 cycles.
  - Continuous requesters each get a turn within 8 grants.
- Hold counter:
  - 8 bits; clears on entry to GRANT and increments every GRANT cycle.
  - Forced release occurs after exactly HOLD_MAX cycles of GNT_VLD=1.
- TIMEOUT is registered. It is high for exactly the one cycle in which GNT_VLD first reads 0 after a forced release.
- GNT is combinational from registered GNT_IDX/GNT_VLD, so it is glitch-free relative to CLK.

## Configuration
- ARB_TIMEOUT_EN defined:
  - Hold counter, HOLD_MAX compare and TIMEOUT generation are compiled in.
- ARB_TIMEOUT_EN undefined:
  - No counter is built; HOLD_MAX is unused.
  - TIMEOUT is tied 0.
  - A grant is held indefinitely until DONE or request withdrawal.

## Structure
- Shared package holds:
  - N_REQ=8, IDX_W=3, CNT_W=8.
  - State encodings: ST_IDLE=1'b0, ST_GRANT=1'b1.
- One sub-module: dec3to8, a pure combinational 3-to-8 decoder with an enable input.
  - Instantiated once to build GNT from GNT_IDX and GNT_VLD.
- Round-robin search: rotate REQ right by PTR, apply a priority encoder, then add PTR mod 8.

## Test plan
- Reset: hold RST_N=0 with REQ=8'hFF, then release. GNT=0 and GNT_VLD=0 while in reset. After one edge, GNT=8'h01 and GNT_IDX=0.
- Fairness: REQ=8'hFF held, DONE pulsed every 2nd GRANT cycle. GNT_IDX sequence is 0,1,2,…,7,0. The 7→0 step confirms PTR wrap-around.
- Skipping: PTR=5, REQ=8'b0000_0110. Grant goes to 1; the following grant goes to 2; PTR then becomes 3.
- Withdrawal: grant to 3, then REQ[3]←0 with DONE=0. GNT_VLD drops after 1 edge and TIMEOUT=0.
- Timeout (ARB_TIMEOUT_EN, HOLD_MAX=4): REQ=8'h10, DONE=0.
  - GNT_VLD is high for exactly 4 cycles, then drops; TIMEOUT pulses for 1 cycle.
  - Regrant to 4 follows after 1 IDLE cycle.
  - Repeat with DONE=1 in the 4th cycle: TIMEOUT stays 0.
- Reset mid-grant: grant to 6, then RST_N=0 asynchronously between edges. GNT clears at once. After release with REQ=8'h41, the grant goes to 0 (PTR=0).
